alu_accumulator_seq: RTL

Parametrised, handshaked successor to the 32-bit accumulator ALU. Executes the team's 16 opcodes on a WIDTH-bit datapath. Adds a valid/ready input handshake, a registered result strobe and explicit reset. Division, modulus and exponent run on multi-cycle iterative engines instead of combinational ones. It sits between the middleware command interface and the result/error reporting path.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/seq_divider.sv | 58 +++++
 rtl/alu_accumulator_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, error-code and FSM-state constants for the handshaked accumulator ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XNOR = 4'd10;
  localparam logic [3:0] OP_XOR  = 4'd11;
  localparam logic [3:0] OP_CLR  = 4'd12;
  localparam logic [3:0] OP_SET  = 4'd13;
  localparam logic [3:0] OP_NOP  = 4'd14;
  localparam logic [3:0] OP_EXP  = 4'd15;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_RSVD = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] EXP  = 2'd2;

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles after start.
// done is high during the final iteration cycle; quotient/remainder then hold the final values.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic [CW-1:0]    cnt;
  logic             active;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;

  // quoReg shifts the dividend out of its top while quotient bits enter at the bottom.
  always_comb begin
    shifted   = {remReg, quoReg[WIDTH-1]};
    trial     = shifted - {1'b0, divReg};
    fits      = ~trial[WIDTH];
    remainder = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quotient  = {quoReg[WIDTH-2:0], fits};
    done      = active && (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remReg <= '0;
      quoReg <= '0;
      divReg <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      remReg <= '0;
      quoReg <= dividend;
      divReg <= divisor;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      remReg <= remainder;
      quoReg <= quotient;
      cnt    <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_accumulator_seq.sv
// Handshaked WIDTH-bit accumulator ALU: single-cycle ops complete at acceptance,
// div/mod use seq_divider and exponent runs a square-and-multiply engine here.
module alu_accumulator_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_code,
  input  logic [WIDTH-1:0] operand_p,
  input  logic [WIDTH-1:0] operand_q,
  input  logic             use_acc,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       error_code,
  output logic             busy,
  output logic [1:0]       dbgState
);

  import alu_pkg::*;

  localparam int CW = $clog2(WIDTH);

  // Handshake: a command transfers on a rising edge with in_valid && in_ready;
  // in_ready is high only in IDLE, out_valid is a one-cycle strobe with no backpressure.
  logic [1:0]         state;
  logic [WIDTH-1:0]   acc;
  logic               modSel;
  logic [WIDTH-1:0]   opB;
  logic               divByZero;
  logic               divStart;
  logic               divDone;
  logic [WIDTH-1:0]   divQuo;
  logic [WIDTH-1:0]   divRem;

  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     subDiff;
  logic [2*WIDTH-1:0] mulProd;
  logic [WIDTH-1:0]   scResult;
  logic [1:0]         scErr;
  logic               scAccWrite;

  logic [WIDTH-1:0]   expRes;
  logic [WIDTH-1:0]   expBase;
  logic [WIDTH-1:0]   expBits;
  logic [CW-1:0]      expCnt;
  logic               expOvf;
  logic [2*WIDTH-1:0] expSq;
  logic [2*WIDTH-1:0] expMul;
  logic               expBit;
  logic [WIDTH-1:0]   expNext;
  logic               expStepOvf;
  logic               expLast;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign dbgState = state;

  assign opB       = use_acc ? acc : operand_q;
  assign divByZero = isDivOp(op_code) && (operand_p == '0);
  assign divStart  = in_valid && (state == IDLE) && isDivOp(op_code) && !divByZero;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (divStart),
    .dividend  (opB),
    .divisor   (operand_p),
    .done      (divDone),
    .quotient  (divQuo),
    .remainder (divRem)
  );

  always_comb begin
    addSum     = {1'b0, operand_p} + {1'b0, opB};
    subDiff    = {1'b0, operand_p} - {1'b0, opB};
    mulProd    = {{WIDTH{1'b0}}, operand_p} * {{WIDTH{1'b0}}, opB};
    scResult   = '0;
    scErr      = ERR_NONE;
    scAccWrite = 1'b1;
    case (op_code)
      OP_ADD: begin
        scResult = addSum[WIDTH-1:0];
        if (addSum[WIDTH]) scErr = ERR_OVF;
      end
      OP_SUB: begin
        scResult = subDiff[WIDTH-1:0];
        if (subDiff[WIDTH]) scErr = ERR_OVF;
      end
      OP_MUL: begin
        scResult = mulProd[WIDTH-1:0];
        if (|mulProd[2*WIDTH-1:WIDTH]) scErr = ERR_OVF;
      end
      // Only reached with a zero divisor; nonzero divisors go to the DIV state.
      OP_DIV, OP_MOD: begin
        scResult   = '1;
        scErr      = ERR_DIV0;
        scAccWrite = 1'b0;
      end
      OP_AND:  scResult = operand_p & opB;
      OP_NAND: scResult = ~(operand_p & opB);
      OP_NOR:  scResult = ~(operand_p | opB);
      OP_NOT:  scResult = ~operand_p;
      OP_OR:   scResult = operand_p | opB;
      OP_XNOR: scResult = ~(operand_p ^ opB);
      OP_XOR:  scResult = operand_p ^ opB;
      OP_CLR:  scResult = '0;
      OP_SET:  scResult = '1;
      OP_NOP:  scResult = acc;
      OP_EXP:  scAccWrite = 1'b0;
      default: scAccWrite = 1'b0;
    endcase
  end

  // One exponent bit per cycle, MSB first: square, then multiply by the base if the bit is set.
  always_comb begin
    expSq      = {{WIDTH{1'b0}}, expRes} * {{WIDTH{1'b0}}, expRes};
    expMul     = {{WIDTH{1'b0}}, expSq[WIDTH-1:0]} * {{WIDTH{1'b0}}, expBase};
    expBit     = expBits[WIDTH-1];
    expNext    = expBit ? expMul[WIDTH-1:0] : expSq[WIDTH-1:0];
    expStepOvf = (|expSq[2*WIDTH-1:WIDTH]) | (expBit & (|expMul[2*WIDTH-1:WIDTH]));
    expLast    = (expCnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      result     <= '0;
      error_code <= ERR_NONE;
      out_valid  <= 1'b0;
      modSel     <= 1'b0;
      expRes     <= '0;
      expBase    <= '0;
      expBits    <= '0;
      expCnt     <= '0;
      expOvf     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divStart) begin
              state  <= DIV;
              modSel <= (op_code == OP_MOD);
            end else if (op_code == OP_EXP) begin
              state   <= EXP;
              expRes  <= WIDTH'(1);
              expBase <= operand_p;
              expBits <= opB;
              expCnt  <= '0;
              expOvf  <= 1'b0;
            end else begin
              result     <= scResult;
              error_code <= scErr;
              out_valid  <= 1'b1;
              if (scAccWrite) acc <= scResult;
            end
          end
        end
        DIV: begin
          if (divDone) begin
            state      <= IDLE;
            result     <= modSel ? divRem : divQuo;
            acc        <= modSel ? divRem : divQuo;
            error_code <= ERR_NONE;
            out_valid  <= 1'b1;
          end
        end
        EXP: begin
          expRes  <= expNext;
          expBits <= {expBits[WIDTH-2:0], 1'b0};
          expCnt  <= expCnt + 1'b1;
          expOvf  <= expOvf | expStepOvf;
          if (expLast) begin
            state      <= IDLE;
            result     <= expNext;
            acc        <= expNext;
            error_code <= (expOvf | expStepOvf) ? ERR_OVF : ERR_NONE;
            out_valid  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
